entrada_coordenadas: RTL and testbench

- Input-side counterpart of the multiplexed display path. Takes three raw board push-buttons (inc, dec, confirma) and produces the values that the display shows: `mapa`, `coordColuna` and `coordLinha`.
- Each button passes through a 2-FF synchronizer, a debouncer and a press-edge detector. A mode-driven FSM then updates the values and emits a one-cycle shot pulse.
- Sits between the board buttons and the game/display logic.

---
 rtl/entrada_coordenadas.sv | 180 ++++++++++++++++++
 tb/tb_entrada_coordenadas.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/entrada_coordenadas.sv
// Button front end (sync, debounce, press edge) and mode-driven FSM for map/column/row selection.
// Optional macro AUTO_REPEAT_EN: held inc/dec repeats every REPEAT_CYCLES cycles.
module entrada_coordenadas #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ATAQUE,
  input  logic       PREPARACAO,
  input  logic       DESLIGADO,
  input  logic       btn_inc_n,
  input  logic       btn_dec_n,
  input  logic       btn_confirma_n,
  output logic [2:0] mapa,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic       campo_linha,
  output logic       mapa_ok,
  output logic       disparo
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("entrada_coordenadas: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {M_DESL, M_PREP, M_ATAQ} mode_t;
  typedef enum logic [2:0] {S_DESL, S_PREP, S_SEL_COL, S_SEL_LIN, S_DISPARO} state_t;

  // Bit order everywhere: [0]=inc, [1]=dec, [2]=confirma.
  logic [2:0]       sync1, sync2;
  logic [2:0]       level, level_d, press, ev;
  logic [CNT_W-1:0] cnt [3];
  mode_t            mode;
  state_t           state;
  logic             inc_ev, dec_ev, conf_ev;

  function automatic logic [2:0] wrap_step(input logic [2:0] v, input logic up, input logic down);
    if (up) return v + 3'd1;
    if (down) return v - 3'd1;
    return v;
  endfunction

  // Button conditioning: raw -> 2FF sync -> debounce -> registered press edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= 3'b111;
      sync2   <= 3'b111;
      level   <= 3'b000;
      level_d <= 3'b000;
      press   <= 3'b000;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1   <= {btn_confirma_n, btn_dec_n, btn_inc_n};
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 3; i++) begin
        if (~sync2[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= ~level[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    mode = M_DESL;
    if (!DESLIGADO && ATAQUE) mode = M_ATAQ;
    else if (!DESLIGADO && PREPARACAO) mode = M_PREP;
  end

`ifdef AUTO_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_FIRE = RCNT_W'(REPEAT_CYCLES);

  mode_t             mode_q;
  logic [RCNT_W-1:0] rcnt [2];
  logic [1:0]        rep;

  // Counter starts on the press-pulse edge, so repeats land R, 2R, ... cycles after it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q <= M_DESL;
      rep    <= 2'b00;
      for (int i = 0; i < 2; i++) rcnt[i] <= '0;
    end else begin
      mode_q <= mode;
      for (int i = 0; i < 2; i++) begin
        rep[i] <= 1'b0;
        if (!level[i] || mode != mode_q) begin
          rcnt[i] <= '0;
        end else if (rcnt[i] == RCNT_FIRE) begin
          rcnt[i] <= RCNT_W'(1);
          rep[i]  <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev = {press[2], press[1] | rep[1], press[0] | rep[0]};
`else
  assign ev = press;
`endif

  assign conf_ev = ev[2];
  assign inc_ev  = ev[0] & ~ev[1] & ~ev[2];
  assign dec_ev  = ev[1] & ~ev[0] & ~ev[2];

  // Mode FSM: mode is re-evaluated every cycle and overrides the current state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_DESL;
      mapa        <= 3'd0;
      coordColuna <= 3'd0;
      coordLinha  <= 3'd0;
      campo_linha <= 1'b0;
      mapa_ok     <= 1'b0;
      disparo     <= 1'b0;
    end else begin
      mapa_ok <= 1'b0;
      disparo <= 1'b0;
      case (mode)
        M_DESL: begin
          state       <= S_DESL;
          mapa        <= 3'd0;
          coordColuna <= 3'd0;
          coordLinha  <= 3'd0;
          campo_linha <= 1'b0;
        end
        M_PREP: begin
          if (state != S_PREP) begin
            state       <= S_PREP;
            campo_linha <= 1'b0;
          end else if (conf_ev) begin
            mapa_ok <= 1'b1;
          end else begin
            mapa <= wrap_step(mapa, inc_ev, dec_ev);
          end
        end
        default: begin
          case (state)
            S_SEL_COL: begin
              if (conf_ev) begin
                state       <= S_SEL_LIN;
                campo_linha <= 1'b1;
              end else begin
                coordColuna <= wrap_step(coordColuna, inc_ev, dec_ev);
              end
            end
            S_SEL_LIN: begin
              if (conf_ev) begin
                state   <= S_DISPARO;
                disparo <= 1'b1;
              end else begin
                coordLinha <= wrap_step(coordLinha, inc_ev, dec_ev);
              end
            end
            default: begin
              state       <= S_SEL_COL;
              campo_linha <= 1'b0;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entrada_coordenadas.sv
// Bench for entrada_coordenadas: event-level model of the selection rules, checked every cycle.
module tb_entrada_coordenadas;
  localparam int D = 16;
  localparam int R = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ATAQUE = 1'b0, PREPARACAO = 1'b1, DESLIGADO = 1'b0;
  logic btn_inc_n = 1'b1, btn_dec_n = 1'b1, btn_confirma_n = 1'b1;
  logic [2:0] mapa, coordColuna, coordLinha;
  logic campo_linha, mapa_ok, disparo;

  int checks = 0, failures = 0;
  int disp_cycles = 0, ok_cycles = 0;

  typedef enum {MS_DESL, MS_PREP, MS_COL, MS_LIN, MS_DISP} ms_t;
  ms_t  ms = MS_DESL;
  int   exp_mapa = 0, exp_col = 0, exp_lin = 0;
  logic exp_campo = 1'b0, exp_ok = 1'b0, exp_disp = 1'b0;

  entrada_coordenadas #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clock(clock), .reset(reset),
    .ATAQUE(ATAQUE), .PREPARACAO(PREPARACAO), .DESLIGADO(DESLIGADO),
    .btn_inc_n(btn_inc_n), .btn_dec_n(btn_dec_n), .btn_confirma_n(btn_confirma_n),
    .mapa(mapa), .coordColuna(coordColuna), .coordLinha(coordLinha),
    .campo_linha(campo_linha), .mapa_ok(mapa_ok), .disparo(disparo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int wrap8(input int v, input logic [2:0] m);
    if (m[0] && !m[1]) return (v + 1) % 8;
    if (m[1] && !m[0]) return (v + 7) % 8;
    return v;
  endfunction

  // One clock edge of the model; m is the set of accepted presses landing on this edge.
  task automatic tick(input logic [2:0] m);
    @(posedge clock);
    exp_ok   = 1'b0;
    exp_disp = 1'b0;
    if (reset || DESLIGADO || (!ATAQUE && !PREPARACAO)) begin
      ms = MS_DESL; exp_mapa = 0; exp_col = 0; exp_lin = 0; exp_campo = 1'b0;
    end else if (!ATAQUE) begin
      if (ms != MS_PREP) begin
        ms = MS_PREP; exp_campo = 1'b0;
      end else if (m[2]) exp_ok = 1'b1;
      else exp_mapa = wrap8(exp_mapa, m);
    end else begin
      if (ms == MS_DESL || ms == MS_PREP || ms == MS_DISP) begin
        ms = MS_COL; exp_campo = 1'b0;
      end else if (ms == MS_COL) begin
        if (m[2]) begin ms = MS_LIN; exp_campo = 1'b1; end
        else exp_col = wrap8(exp_col, m);
      end else begin
        if (m[2]) begin ms = MS_DISP; exp_disp = 1'b1; end
        else exp_lin = wrap8(exp_lin, m);
      end
    end
    #1;
  endtask

  task automatic drive_btns(input logic [2:0] m);
    btn_inc_n = ~m[0]; btn_dec_n = ~m[1]; btn_confirma_n = ~m[2];
  endtask

  // Clean press held D+5 cycles; takes effect at edge N+D+3 after first sample N.
  task automatic press(input logic [2:0] m);
    drive_btns(m);
    tick(3'b000);
    repeat (D + 2) tick(3'b000);
    tick(m);
    tick(3'b000);
    drive_btns(3'b000);
    repeat (D + 6) tick(3'b000);
  endtask

  task automatic set_mode(input logic a, input logic p, input logic d);
    ATAQUE = a; PREPARACAO = p; DESLIGADO = d;
    tick(3'b000);
  endtask

  // Compare process: every output, every cycle, on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      check("mapa", {5'b0, mapa}, 8'(exp_mapa));
      check("coordColuna", {5'b0, coordColuna}, 8'(exp_col));
      check("coordLinha", {5'b0, coordLinha}, 8'(exp_lin));
      check("campo_linha", {7'b0, campo_linha}, {7'b0, exp_campo});
      check("mapa_ok", {7'b0, mapa_ok}, {7'b0, exp_ok});
      check("disparo", {7'b0, disparo}, {7'b0, exp_disp});
      if (disparo === 1'b1) disp_cycles++;
      if (mapa_ok === 1'b1) ok_cycles++;
    end
  end

  initial begin
    int hold;
    int start_col;
    repeat (2) tick(3'b000);
    check("reset_mapa", {5'b0, mapa}, 8'd0);
    check("reset_campo", {7'b0, campo_linha}, 8'd0);
    repeat (3) press(3'b001);
    check("inc_in_reset", {5'b0, mapa}, 8'd0);

    reset = 1'b0;
    tick(3'b000);
    repeat (3) press(3'b001);
    check("mapa_after_3inc", {5'b0, mapa}, 8'd3);
    repeat (4) press(3'b010);
    check("mapa_wrap_dec", {5'b0, mapa}, 8'd7);
    press(3'b100);
    check("mapa_ok_cycles", 8'(ok_cycles), 8'd1);
    check("mapa_held_conf", {5'b0, mapa}, 8'd7);

    // Glitch shorter than the debounce window
    drive_btns(3'b001);
    repeat (D - 2) tick(3'b000);
    drive_btns(3'b000);
    repeat (D + 6) tick(3'b000);
    check("glitch_ignored", {5'b0, mapa}, 8'd7);

    // Pinned latency: old value after edge N+D+2, new value after edge N+D+3
    drive_btns(3'b001);
    tick(3'b000);
    repeat (D + 2) tick(3'b000);
    check("latency_before", {5'b0, mapa}, 8'd7);
    tick(3'b001);
    check("latency_after_wrap", {5'b0, mapa}, 8'd0);
    tick(3'b000);
    drive_btns(3'b000);
    repeat (D + 6) tick(3'b000);
    check("single_step_hold", {5'b0, mapa}, 8'd0);

    set_mode(1'b1, 1'b0, 1'b0);
    repeat (2) press(3'b001);
    press(3'b100);
    repeat (5) press(3'b001);
    press(3'b100);
    check("col_2", {5'b0, coordColuna}, 8'd2);
    check("lin_5", {5'b0, coordLinha}, 8'd5);
    check("disparo_cycles", 8'(disp_cycles), 8'd1);
    check("campo_after_shot", {7'b0, campo_linha}, 8'd0);

    press(3'b011);
    check("inc_dec_ignored", {5'b0, coordColuna}, 8'd2);
    press(3'b101);
    check("conf_wins_col", {5'b0, coordColuna}, 8'd2);
    check("conf_wins_lin", {7'b0, campo_linha}, 8'd1);

    press(3'b100);
    repeat (2) press(3'b001);
    press(3'b100);
    check("col_4_in_lin", {5'b0, coordColuna}, 8'd4);
    check("lin_state", {7'b0, campo_linha}, 8'd1);
    set_mode(1'b1, 1'b0, 1'b1);
    set_mode(1'b1, 1'b0, 1'b0);
    check("desl_col", {5'b0, coordColuna}, 8'd0);
    check("desl_lin", {5'b0, coordLinha}, 8'd0);
    check("desl_campo", {7'b0, campo_linha}, 8'd0);
    check("desl_no_shot", 8'(disp_cycles), 8'd2);

    // Long hold: accepted at t=D+2, held 3*R+10 more cycles
    start_col = exp_col;
    hold = D + 2 + 3 * R + 10;
    drive_btns(3'b001);
    for (int t = 1; t <= hold; t++) begin
`ifdef AUTO_REPEAT_EN
      tick((t >= D + 4 && ((t - (D + 4)) % R) == 0) ? 3'b001 : 3'b000);
`else
      tick((t == D + 4) ? 3'b001 : 3'b000);
`endif
    end
    drive_btns(3'b000);
    repeat (D + 6) tick(3'b000);
`ifdef AUTO_REPEAT_EN
    check("long_hold", {5'b0, coordColuna}, 8'((start_col + 4) % 8));
`else
    check("long_hold", {5'b0, coordColuna}, 8'((start_col + 1) % 8));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
